// File: rtl/stopwatch_display_scan.sv
// -----------------------------------------------------------------------------
// stopwatch_display_scan
//
// Purpose:
//    Multiplexed driver for a 5-digit common-anode seven-segment display that
//    shows a stopwatch time M:SS:cc. The packed BCD time bus is captured once
//    per scan frame, so a digit never changes in the middle of a frame. Each
//    digit is then lit for SCAN_DIV clock cycles in turn.
//
// Parameters:
//    SCAN_DIV : clock cycles each digit is lit (>= 2)
//    CNT_W    : prescaler width, 2**CNT_W >= SCAN_DIV
//
// Ports:
//    CLK   in   1   system clock
//    RESET in   1   synchronous, active-high reset
//    TIME  in  20   {MIN, TENSEC, SEC, DECISEC, CENTISEC} packed BCD
//    BLANK in   1   1 = all anodes off; scanning keeps running
//    AN    out  5   digit anodes, active-low, AN[0]=CENTISEC .. AN[4]=MIN
//    SEG   out  7   segments {g,f,e,d,c,b,a}, active-low
//    DP    out  1   decimal point, active-low
//    FRAME out  1   one-cycle pulse when a new snapshot is captured
//
// Build option:
//    LEADING_ZERO_BLANK_EN : when defined, a zero minutes digit is blanked,
//    and the tens-of-seconds digit is blanked when it and minutes are zero.
// -----------------------------------------------------------------------------
module stopwatch_display_scan #(
   parameter int SCAN_DIV = 25000,
   parameter int CNT_W    = 15
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [19:0] TIME,
   input  logic        BLANK,
   output logic [4:0]  AN,
   output logic [6:0]  SEG,
   output logic        DP,
   output logic        FRAME
);

   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_idx;
   logic [19:0]      r_snap;
   logic [4:0]       r_an;
   logic [6:0]       r_seg;
   logic             r_dp;
   logic             r_frame;

   logic             w_last;
   logic             w_wrap;
   logic             w_min_zero;
   logic             w_ten_zero;
   logic [6:0]       w_dig_seg [5];
   logic [6:0]       w_seg_sel;

   // BCD to active-low segments; non-decimal codes show a dash.
   function automatic logic [6:0] f_bcd7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h3F;
      endcase
      return s;
   endfunction

   assign w_last     = (r_cnt == CNT_W'(SCAN_DIV - 1));
   assign w_wrap     = w_last && (r_idx == 3'd4);
   assign w_min_zero = (r_snap[19:16] == 4'd0);
   assign w_ten_zero = (r_snap[15:12] == 4'd0);

   // Per-digit segment patterns from the frozen snapshot.
   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_digit
`ifdef LEADING_ZERO_BLANK_EN
         if (gi == 4) begin : g_min
            assign w_dig_seg[gi] = w_min_zero ? 7'h7F : f_bcd7(r_snap[4*gi +: 4]);
         end else if (gi == 3) begin : g_ten
            assign w_dig_seg[gi] = (w_min_zero && w_ten_zero) ? 7'h7F
                                                              : f_bcd7(r_snap[4*gi +: 4]);
         end else begin : g_plain
            assign w_dig_seg[gi] = f_bcd7(r_snap[4*gi +: 4]);
         end
`else
         assign w_dig_seg[gi] = f_bcd7(r_snap[4*gi +: 4]);
`endif
      end
   endgenerate

`ifndef LEADING_ZERO_BLANK_EN
   // Zero-digit flags only matter when leading-zero blanking is built in.
   logic w_unused_zero;
   assign w_unused_zero = w_min_zero ^ w_ten_zero;
`endif

   always_comb begin
      w_seg_sel = 7'h7F;
      case (r_idx)
         3'd0:    w_seg_sel = w_dig_seg[0];
         3'd1:    w_seg_sel = w_dig_seg[1];
         3'd2:    w_seg_sel = w_dig_seg[2];
         3'd3:    w_seg_sel = w_dig_seg[3];
         3'd4:    w_seg_sel = w_dig_seg[4];
         default: w_seg_sel = 7'h7F;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_cnt   <= '0;
         r_idx   <= 3'd0;
         r_snap  <= 20'h0;
         r_an    <= 5'h1F;
         r_seg   <= 7'h7F;
         r_dp    <= 1'b1;
         r_frame <= 1'b0;
      end else begin
         if (w_last) begin
            r_cnt <= '0;
            r_idx <= (r_idx == 3'd4) ? 3'd0 : r_idx + 3'd1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end

         // New snapshot only at the frame boundary keeps digits consistent.
         if (w_wrap) begin
            r_snap <= TIME;
         end
         r_frame <= w_wrap;

         // Display outputs follow the digit index of this cycle (one-cycle lag).
         r_an  <= BLANK ? 5'h1F : ~(5'b00001 << r_idx);
         r_seg <= w_seg_sel;
         r_dp  <= !((r_idx == 3'd2) || (r_idx == 3'd4));
      end
   end

   assign AN    = r_an;
   assign SEG   = r_seg;
   assign DP    = r_dp;
   assign FRAME = r_frame;

endmodule
